// File: rtl/mem_cmd_pkg.sv
// Shared DRAM command encodings and the decoded request record used by the
// scheduler and the downstream command_sender.
package mem_cmd_pkg;

  typedef enum logic [2:0] {
    CMD_READ      = 3'd0,
    CMD_WRITE     = 3'd1,
    CMD_ACTIVATE  = 3'd2,
    CMD_PRECHARGE = 3'd3,
    CMD_NOP       = 3'd7
  } commands;

  // Field widths of the request record; schedulers may use narrower fields.
  localparam int unsigned REQ_BG_BITS  = 3;
  localparam int unsigned REQ_BA_BITS  = 3;
  localparam int unsigned REQ_ROW_BITS = 8;
  localparam int unsigned REQ_COL_BITS = 4;

  typedef struct packed {
    logic                    write;
    logic [REQ_BG_BITS-1:0]  bg;
    logic [REQ_BA_BITS-1:0]  ba;
    logic [REQ_ROW_BITS-1:0] row;
    logic [REQ_COL_BITS-1:0] col;
  } mem_request_t;

  function automatic int unsigned num_banks(input int unsigned bank_groups,
                                            input int unsigned banks_per_group);
    return bank_groups * banks_per_group;
  endfunction

endpackage

// File: rtl/bank_state_table.sv
// Per-bank open-row tracker: one combinational lookup port, one update port,
// synchronous clear of every open flag on reset.
module bank_state_table #(
  parameter int unsigned NUM_BANKS = 64,
  parameter int unsigned ROW_BITS  = 8,
  localparam int unsigned IDX_BITS = $clog2(NUM_BANKS)
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [IDX_BITS-1:0] lookup_idx,
  input  logic [ROW_BITS-1:0] lookup_row,
  output logic                lookup_open,
  output logic                lookup_hit,
  input  logic                update_en,
  input  logic                update_open,
  input  logic [IDX_BITS-1:0] update_idx,
  input  logic [ROW_BITS-1:0] update_row
);

  logic [NUM_BANKS-1:0] open_valid;
  logic [ROW_BITS-1:0]  open_row [NUM_BANKS];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      open_valid <= '0;
    end else if (update_en) begin
      open_valid[update_idx] <= update_open;
    end
  end

  // Row storage needs no reset: it is only consulted while its open flag is set.
  always_ff @(posedge clk_in) begin
    if (update_en && update_open) begin
      open_row[update_idx] <= update_row;
    end
  end

  always_comb begin
    lookup_open = open_valid[lookup_idx];
    lookup_hit  = lookup_open && (open_row[lookup_idx] == lookup_row);
  end

endmodule

// File: rtl/bank_cmd_scheduler.sv
// Open-page scheduler: turns one request at a time into PRE/ACT/CAS commands
// while honouring precharge, activation and CAS-to-CAS spacing.
module bank_cmd_scheduler
  import mem_cmd_pkg::*;
#(
  parameter int unsigned BANK_GROUPS        = 8,
  parameter int unsigned BANKS_PER_GROUP    = 8,
  parameter int unsigned ROW_BITS           = 8,
  parameter int unsigned COL_BITS           = 4,
  parameter int unsigned ACTIVATION_LATENCY = 8,
  parameter int unsigned PRECHARGE_LATENCY  = 5,
  parameter int unsigned CAS_GAP            = 8
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               req_valid_in,
  output logic                               req_ready_out,
  input  logic                               req_write_in,
  input  logic [$clog2(BANK_GROUPS)-1:0]     req_bg_in,
  input  logic [$clog2(BANKS_PER_GROUP)-1:0] req_ba_in,
  input  logic [ROW_BITS-1:0]                req_row_in,
  input  logic [COL_BITS-1:0]                req_col_in,
  input  logic [7:0][63:0]                   req_val_in,
  output logic                               valid_out,
  output logic [2:0]                         cmd_out,
  output logic [$clog2(BANK_GROUPS)-1:0]     bg_out,
  output logic [$clog2(BANKS_PER_GROUP)-1:0] ba_out,
  output logic [ROW_BITS-1:0]                row_out,
  output logic [COL_BITS-1:0]                col_out,
  output logic [7:0][63:0]                   val_out,
  output logic                               cas_done_out
);

  localparam int unsigned BG_BITS    = $clog2(BANK_GROUPS);
  localparam int unsigned BA_BITS    = $clog2(BANKS_PER_GROUP);
  localparam int unsigned NUM_BANKS  = num_banks(BANK_GROUPS, BANKS_PER_GROUP);
  localparam int unsigned IDX_BITS   = $clog2(NUM_BANKS);
  localparam int unsigned MAX_LAT    = (ACTIVATION_LATENCY > PRECHARGE_LATENCY) ?
                                       ACTIVATION_LATENCY : PRECHARGE_LATENCY;
  localparam int unsigned TIMER_BITS = $clog2(MAX_LAT + 1);
  localparam int unsigned GAP_BITS   = $clog2(CAS_GAP + 1);

  localparam logic [TIMER_BITS-1:0] ACT_LOAD = TIMER_BITS'(ACTIVATION_LATENCY - 1);
  localparam logic [TIMER_BITS-1:0] PRE_LOAD = TIMER_BITS'(PRECHARGE_LATENCY - 1);
  localparam logic [GAP_BITS-1:0]   GAP_LOAD = GAP_BITS'(CAS_GAP - 1);

  if (BG_BITS > REQ_BG_BITS || BA_BITS > REQ_BA_BITS ||
      ROW_BITS > REQ_ROW_BITS || COL_BITS > REQ_COL_BITS) begin : g_width_guard
    $error("bank_cmd_scheduler: request field wider than mem_request_t");
  end

  typedef enum logic [2:0] {IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, CAS} state_t;

  state_t                state;
  logic [TIMER_BITS-1:0] timer;
  logic [GAP_BITS-1:0]   gap;
  mem_request_t          req_q;
  logic [7:0][63:0]      val_q;

  logic                  lookup_open;
  logic                  lookup_hit;
  logic [IDX_BITS-1:0]   lookup_idx;
  logic [IDX_BITS-1:0]   update_idx;

  assign lookup_idx = IDX_BITS'(req_bg_in) * IDX_BITS'(BANKS_PER_GROUP) + IDX_BITS'(req_ba_in);
  assign update_idx = IDX_BITS'(req_q.bg) * IDX_BITS'(BANKS_PER_GROUP) + IDX_BITS'(req_q.ba);

  bank_state_table #(
    .NUM_BANKS (NUM_BANKS),
    .ROW_BITS  (ROW_BITS)
  ) u_bank_state_table (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .lookup_idx  (lookup_idx),
    .lookup_row  (req_row_in),
    .lookup_open (lookup_open),
    .lookup_hit  (lookup_hit),
    .update_en   ((state == PRE || state == ACT) && !rst_in),
    .update_open (state == ACT),
    .update_idx  (update_idx),
    .update_row  (req_q.row[ROW_BITS-1:0])
  );

  assign req_ready_out = (state == IDLE) && !rst_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      timer <= '0;
      gap   <= '0;
      req_q <= '0;
      val_q <= '0;
    end else begin
      if (gap != '0) gap <= gap - GAP_BITS'(1);
      case (state)
        IDLE: begin
          if (req_valid_in && req_ready_out) begin
            req_q.write <= req_write_in;
            req_q.bg    <= REQ_BG_BITS'(req_bg_in);
            req_q.ba    <= REQ_BA_BITS'(req_ba_in);
            req_q.row   <= REQ_ROW_BITS'(req_row_in);
            req_q.col   <= REQ_COL_BITS'(req_col_in);
            val_q       <= req_val_in;
            if (!lookup_open)    state <= ACT;
            else if (lookup_hit) state <= CAS;
            else                 state <= PRE;
          end
        end
        PRE: begin
          timer <= PRE_LOAD;
          state <= (PRE_LOAD == '0) ? ACT : PRE_WAIT;
        end
        // Leaving on the 1->0 step makes the next command land exactly LATENCY cycles later.
        PRE_WAIT: begin
          if (timer != '0) timer <= timer - TIMER_BITS'(1);
          if (timer <= TIMER_BITS'(1)) state <= ACT;
        end
        ACT: begin
          timer <= ACT_LOAD;
          state <= (ACT_LOAD == '0) ? CAS : ACT_WAIT;
        end
        ACT_WAIT: begin
          if (timer != '0) timer <= timer - TIMER_BITS'(1);
          if (timer <= TIMER_BITS'(1)) state <= CAS;
        end
        CAS: begin
          if (gap == '0) begin
            gap   <= GAP_LOAD;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    valid_out    = 1'b0;
    cmd_out      = CMD_NOP;
    cas_done_out = 1'b0;
    if (!rst_in) begin
      case (state)
        PRE: begin
          valid_out = 1'b1;
          cmd_out   = CMD_PRECHARGE;
        end
        ACT: begin
          valid_out = 1'b1;
          cmd_out   = CMD_ACTIVATE;
        end
        CAS: begin
          if (gap == '0) begin
            valid_out    = 1'b1;
            cmd_out      = req_q.write ? CMD_WRITE : CMD_READ;
            cas_done_out = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bg_out  = req_q.bg[BG_BITS-1:0];
  assign ba_out  = req_q.ba[BA_BITS-1:0];
  assign row_out = req_q.row[ROW_BITS-1:0];
  assign col_out = req_q.col[COL_BITS-1:0];
  assign val_out = val_q;

endmodule

// File: tb/tb_bank_cmd_scheduler.sv
// Directed bench for bank_cmd_scheduler: closed/hit/conflict sequences, CAS
// spacing, write data hold and reset abandoning an open sequence.
module tb_bank_cmd_scheduler;

  logic             clk_in;
  logic             rst_in;
  logic             req_valid_in;
  logic             req_ready_out;
  logic             req_write_in;
  logic [2:0]       req_bg_in;
  logic [2:0]       req_ba_in;
  logic [7:0]       req_row_in;
  logic [3:0]       req_col_in;
  logic [7:0][63:0] req_val_in;
  logic             valid_out;
  logic [2:0]       cmd_out;
  logic [2:0]       bg_out;
  logic [2:0]       ba_out;
  logic [7:0]       row_out;
  logic [3:0]       col_out;
  logic [7:0][63:0] val_out;
  logic             cas_done_out;

  int errors = 0;
  int checks = 0;

  logic [7:0][63:0] wdata_a;
  logic [7:0][63:0] wdata_b;

  bank_cmd_scheduler #(
    .BANK_GROUPS        (8),
    .BANKS_PER_GROUP    (8),
    .ROW_BITS           (8),
    .COL_BITS           (4),
    .ACTIVATION_LATENCY (8),
    .PRECHARGE_LATENCY  (5),
    .CAS_GAP            (8)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .req_valid_in  (req_valid_in),
    .req_ready_out (req_ready_out),
    .req_write_in  (req_write_in),
    .req_bg_in     (req_bg_in),
    .req_ba_in     (req_ba_in),
    .req_row_in    (req_row_in),
    .req_col_in    (req_col_in),
    .req_val_in    (req_val_in),
    .valid_out     (valid_out),
    .cmd_out       (cmd_out),
    .bg_out        (bg_out),
    .ba_out        (ba_out),
    .row_out       (row_out),
    .col_out       (col_out),
    .val_out       (val_out),
    .cas_done_out  (cas_done_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_data(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Offer one request while the scheduler is idle; returns in the cycle after transfer.
  task automatic send(input string tag, input logic wr, input logic [2:0] bg,
                      input logic [2:0] ba, input logic [7:0] row, input logic [3:0] col);
    chk({tag, " ready"}, 64'(req_ready_out), 64'(1));
    req_write_in = wr;
    req_bg_in    = bg;
    req_ba_in    = ba;
    req_row_in   = row;
    req_col_in   = col;
    req_valid_in = 1'b1;
    step();
    req_valid_in = 1'b0;
  endtask

  task automatic expect_cmd(input string tag, input logic [2:0] cmd, input logic [2:0] bg,
                            input logic [2:0] ba, input logic [7:0] row, input logic [3:0] col);
    chk({tag, " valid"}, 64'(valid_out), 64'(1));
    chk({tag, " cmd"}, 64'(cmd_out), 64'(cmd));
    chk({tag, " target"}, 64'({bg_out, ba_out, row_out, col_out}), 64'({bg, ba, row, col}));
    chk({tag, " cas_done"}, 64'(cas_done_out), 64'(cmd <= 3'd1));
    step();
  endtask

  task automatic quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, " idle-cmd"}, 64'({valid_out, cmd_out, cas_done_out}), 64'({1'b0, 3'd7, 1'b0}));
      step();
    end
  endtask

  initial begin
    rst_in       = 1'b1;
    req_valid_in = 1'b0;
    req_write_in = 1'b0;
    req_bg_in    = '0;
    req_ba_in    = '0;
    req_row_in   = '0;
    req_col_in   = '0;
    req_val_in   = '0;
    for (int i = 0; i < 8; i++) begin
      wdata_a[i] = 64'(i);
      wdata_b[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
    end

    // Reset state
    step();
    step();
    chk("rst ready", 64'(req_ready_out), 64'(0));
    chk("rst outputs", 64'({valid_out, cmd_out, cas_done_out}), 64'({1'b0, 3'd7, 1'b0}));
    chk("rst target", 64'({bg_out, ba_out, row_out, col_out}), 64'(0));
    chk_data("rst val", val_out, 512'(0));
    rst_in = 1'b0;
    #1;
    chk("post-rst ready", 64'(req_ready_out), 64'(1));

    // Closed bank: ACT at T+1, READ at T+9
    send("closed", 1'b0, 3'd0, 3'd0, 8'd5, 4'd3);
    expect_cmd("closed act", 3'd2, 3'd0, 3'd0, 8'd5, 4'd3);
    quiet("closed act-wait", 7);
    expect_cmd("closed read", 3'd0, 3'd0, 3'd0, 8'd5, 4'd3);

    // Two back-to-back row hits: each CAS exactly CAS_GAP after the previous one
    send("hit1", 1'b0, 3'd0, 3'd0, 8'd5, 4'd6);
    quiet("hit1 gap", 6);
    expect_cmd("hit1 read", 3'd0, 3'd0, 3'd0, 8'd5, 4'd6);
    send("hit2", 1'b0, 3'd0, 3'd0, 8'd5, 4'd7);
    quiet("hit2 gap", 6);
    expect_cmd("hit2 read", 3'd0, 3'd0, 3'd0, 8'd5, 4'd7);

    // Row conflict; a request held while busy must not disturb the sequence
    send("conflict", 1'b0, 3'd0, 3'd0, 8'd9, 4'd1);
    req_valid_in = 1'b1;
    req_bg_in    = 3'd5;
    req_row_in   = 8'hEE;
    chk("busy ready", 64'(req_ready_out), 64'(0));
    expect_cmd("conflict pre", 3'd3, 3'd0, 3'd0, 8'd9, 4'd1);
    quiet("conflict pre-wait", 4);
    expect_cmd("conflict act", 3'd2, 3'd0, 3'd0, 8'd9, 4'd1);
    quiet("conflict act-wait", 7);
    req_valid_in = 1'b0;
    expect_cmd("conflict read", 3'd0, 3'd0, 3'd0, 8'd9, 4'd1);

    // Write with burst data, then a hit read to the same (now open) bank
    req_val_in = wdata_a;
    send("write", 1'b1, 3'd2, 3'd1, 8'h33, 4'hA);
    req_val_in = wdata_b;
    expect_cmd("write act", 3'd2, 3'd2, 3'd1, 8'h33, 4'hA);
    quiet("write act-wait", 7);
    chk_data("write val", val_out, wdata_a);
    expect_cmd("write cas", 3'd1, 3'd2, 3'd1, 8'h33, 4'hA);
    chk_data("write val held", val_out, wdata_a);
    send("write hit", 1'b0, 3'd2, 3'd1, 8'h33, 4'h4);
    chk_data("read val latched", val_out, wdata_b);
    quiet("write hit gap", 6);
    expect_cmd("write hit read", 3'd0, 3'd2, 3'd1, 8'h33, 4'h4);

    // Reset during ACT_WAIT abandons the request and closes the bank
    send("abandon", 1'b0, 3'd1, 3'd3, 8'd7, 4'd2);
    expect_cmd("abandon act", 3'd2, 3'd1, 3'd3, 8'd7, 4'd2);
    quiet("abandon act-wait", 2);
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    #1;
    chk("mid-rst ready", 64'(req_ready_out), 64'(1));
    chk("mid-rst target", 64'({bg_out, ba_out, row_out, col_out}), 64'(0));
    quiet("mid-rst no cas", 10);
    send("reopen", 1'b0, 3'd1, 3'd3, 8'd7, 4'd2);
    expect_cmd("reopen act", 3'd2, 3'd1, 3'd3, 8'd7, 4'd2);
    quiet("reopen act-wait", 7);
    expect_cmd("reopen read", 3'd0, 3'd1, 3'd3, 8'd7, 4'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
